// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: opcode encodings, controller
// state encoding and the bit positions of the packed status-flag vector.
// -----------------------------------------------------------------------------
package alu_pkg;

  // Opcodes carried on exe_cmd
  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_ADC = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SBC = 4'b0101;
  localparam logic [3:0] OP_AND = 4'b0110;
  localparam logic [3:0] OP_ORR = 4'b0111;
  localparam logic [3:0] OP_EOR = 4'b1000;
  localparam logic [3:0] OP_MVN = 4'b1001;
  localparam logic [3:0] OP_MUL = 4'b1010;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_BUSY = 2'd1,
    ST_HOLD     = 2'd2
  } state_t;

  // Positions inside the packed flag vector
  localparam int FLAG_V = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;
  localparam int FLAG_W = 4;

  // Flags describing a zero result with no carry/overflow (reset value)
  localparam logic [FLAG_W-1:0] FLAGS_ZERO = FLAG_W'(1) << FLAG_Z;

endpackage

// File: rtl/alu_seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
// Iterative shift-add multiplier producing the low WIDTH bits of a*b, one
// multiplier bit per clock.
//   clk, rst      : clock, asynchronous active-low reset
//   start         : load a/b and begin (one-cycle pulse)
//   a, b          : operands, sampled when start is high
//   busy          : iteration in progress
//   done          : high during the final iteration cycle; product is valid
//                   (combinationally) in that same cycle
//   product       : low WIDTH bits of a*b when done is high
// -----------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] mplier_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] partial_next;
  logic             last_iter;

  // Accumulate the (already shifted) multiplicand when the current
  // multiplier bit is set; only the low WIDTH bits are ever needed.
  assign partial_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign last_iter    = busy_reg && (cnt_reg == CNT_W'(WIDTH - 1));

  assign busy    = busy_reg;
  assign done    = last_iter;
  assign product = partial_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= a;
      mplier_reg <= b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= partial_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CNT_W'(1);
      if (last_iter) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Valid/ready ALU. Single-cycle operations complete the cycle after they are
// accepted; MUL runs through an iterative multiplier and completes WIDTH+1
// cycles after acceptance. The result and flags are held until consumed.
//   clk, rst            : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake
//   exe_cmd             : opcode (see alu_pkg)
//   val1, val2, c_in    : operands and carry-in, captured on acceptance
//   out_valid/out_ready : result handshake
//   alu_res, n,z,c,v    : result and its status flags
// -----------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       exe_cmd,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_res,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  localparam int MSB = WIDTH - 1;

  state_t            state_reg, state_next;
  logic [WIDTH-1:0]  res_reg, res_next;
  logic [FLAG_W-1:0] flags_reg, flags_next;
  logic              valid_reg, valid_next;
  logic              mul_cin_reg, mul_cin_next;
  logic              run_reg;

  logic              accept;
  logic              is_mul;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [WIDTH-1:0]  mul_product;

  logic [WIDTH:0]    add_w;
  logic [WIDTH:0]    sub_w;
  logic              carry_add;
  logic              borrow_in;
  logic [WIDTH-1:0]  op_res;
  logic              op_c;
  logic              op_v;
  logic [FLAG_W-1:0] op_flags;
  logic [FLAG_W-1:0] mul_flags;

  // run_reg holds in_ready low until the first edge after reset release,
  // so nothing can be accepted while the block is still coming out of reset.
  assign in_ready = run_reg && !mul_busy &&
                    ((state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && out_ready));
  assign accept   = in_valid && in_ready;
  assign is_mul   = (MUL_EN != 0) && (exe_cmd == OP_MUL);

  // ---------------------------------------------------------------------------
  // Single-cycle datapath (one extra bit to expose carry / borrow)
  // ---------------------------------------------------------------------------
  assign carry_add = (exe_cmd == OP_ADC) ? c_in : 1'b0;
  assign borrow_in = (exe_cmd == OP_SBC) ? ~c_in : 1'b0;
  assign add_w = {1'b0, val1} + {1'b0, val2} + {{WIDTH{1'b0}}, carry_add};
  assign sub_w = {1'b0, val1} - {1'b0, val2} - {{WIDTH{1'b0}}, borrow_in};

  always_comb begin
    op_res = '0;
    op_c   = 1'b0;
    op_v   = 1'b0;
    case (exe_cmd)
      OP_MOV: op_res = val2;
      OP_MVN: op_res = ~val2;
      OP_ADD, OP_ADC: begin
        op_res = add_w[MSB:0];
        op_c   = add_w[WIDTH];
        op_v   = (val1[MSB] == val2[MSB]) && (op_res[MSB] != val1[MSB]);
      end
      OP_SUB, OP_SBC: begin
        op_res = sub_w[MSB:0];
        // A wrap of the extended difference means a borrow; c is its inverse.
        op_c   = ~sub_w[WIDTH];
        op_v   = (val1[MSB] != val2[MSB]) && (op_res[MSB] != val1[MSB]);
      end
      OP_AND: op_res = val1 & val2;
      OP_ORR: op_res = val1 | val2;
      OP_EOR: op_res = val1 ^ val2;
      default: ; // undefined, and MUL which is handled by the multiplier
    endcase

    op_flags         = '0;
    op_flags[FLAG_N] = op_res[MSB];
    op_flags[FLAG_Z] = (op_res == '0);
    op_flags[FLAG_C] = op_c;
    op_flags[FLAG_V] = op_v;

    mul_flags         = '0;
    mul_flags[FLAG_N] = mul_product[MSB];
    mul_flags[FLAG_Z] = (mul_product == '0);
    mul_flags[FLAG_C] = mul_cin_reg;
  end

  // ---------------------------------------------------------------------------
  // Multiplier (absent when MUL_EN is 0; MUL then decodes as undefined)
  // ---------------------------------------------------------------------------
  generate
    if (MUL_EN != 0) begin : g_mul
      seq_multiplier #(
        .WIDTH(WIDTH)
      ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (val1),
        .b       (val2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Controller: next state and output registers
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    res_next     = res_reg;
    flags_next   = flags_reg;
    valid_next   = valid_reg;
    mul_cin_next = mul_cin_reg;
    mul_start    = 1'b0;

    case (state_reg)
      ST_MUL_BUSY: begin
        if (mul_done) begin
          state_next = ST_HOLD;
          res_next   = mul_product;
          flags_next = mul_flags;
          valid_next = 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_next = ST_IDLE;
          valid_next = 1'b0;
        end
      end
      default: ;
    endcase

    // A new request can only be accepted from IDLE or from HOLD while the
    // current result is being consumed, so it overrides the moves above.
    if (accept) begin
      if (is_mul) begin
        state_next   = ST_MUL_BUSY;
        valid_next   = 1'b0;
        mul_start    = 1'b1;
        mul_cin_next = c_in;
      end else begin
        state_next = ST_HOLD;
        res_next   = op_res;
        flags_next = op_flags;
        valid_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      res_reg     <= '0;
      flags_reg   <= FLAGS_ZERO;
      valid_reg   <= 1'b0;
      mul_cin_reg <= 1'b0;
      run_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      res_reg     <= res_next;
      flags_reg   <= flags_next;
      valid_reg   <= valid_next;
      mul_cin_reg <= mul_cin_next;
      run_reg     <= 1'b1;
    end
  end

  assign out_valid = valid_reg;
  assign alu_res   = res_reg;
  assign n         = flags_reg[FLAG_N];
  assign z         = flags_reg[FLAG_Z];
  assign c         = flags_reg[FLAG_C];
  assign v         = flags_reg[FLAG_V];

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving operand/result width (legal 8..64).
REQ-002 The block SHALL have parameter MUL_EN, default 1; when 1 the multiply opcode is supported.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous assert, active-low (0 = reset), synchronous release.
REQ-005 Port in_valid  input  1  operation request valid.
REQ-006 Port in_ready  output  1  block accepts a request this cycle.
REQ-007 Port exe_cmd  input  4  opcode.
REQ-008 Port val1, val2  input  WIDTH  operands.
REQ-009 Port c_in  input  1  carry flag in.
REQ-010 Port out_valid  output  1  result/flags valid.
REQ-011 Port out_ready  input  1  consumer takes result.
REQ-012 Port alu_res  output  WIDTH  result.
REQ-013 Port n, z, c, v  output  1 each  status flags for alu_res.

Function
REQ-014 Opcodes SHALL be: 0001 MOV(val2), 1001 MVN(~val2), 0010 ADD, 0011 ADC(+c_in), 0100 SUB, 0101 SBC(-~c_in), 0110 AND, 0111 ORR, 1000 EOR, 1010 MUL (low WIDTH bits of val1*val2); any other code -> result 0, all flags 0 except z=1.
REQ-015 Add/sub SHALL be computed at WIDTH+1 bits; c = bit WIDTH for ADD/ADC; c = NOT borrow (1 when val1 >= val2 + borrow-in, unsigned) for SUB/SBC.
REQ-016 v SHALL be signed overflow for ADD/ADC/SUB/SBC, 0 otherwise; c SHALL be 0 for logic/MOV/MVN, and equal the captured c_in for MUL.
REQ-017 n = alu_res[WIDTH-1]; z = (alu_res == 0), for every opcode.
REQ-018 A request SHALL be accepted on a cycle with in_valid && in_ready; operands, opcode, c_in captured at acceptance, ignored otherwise.
REQ-019 FSM states IDLE, MUL_BUSY, HOLD; IDLE --accept non-MUL--> HOLD; IDLE --accept MUL--> MUL_BUSY; MUL_BUSY --counter reaches WIDTH--> HOLD; HOLD --out_ready--> IDLE, or directly to HOLD/MUL_BUSY if a new request is accepted same cycle.
REQ-020 in_ready = (state == IDLE) || (state == HOLD && out_ready); never high in MUL_BUSY.
REQ-021 Non-MUL latency SHALL be 1: out_valid high the cycle after acceptance; back-to-back throughput 1/cycle while out_ready held high.
REQ-022 MUL SHALL be iterative shift-add, one bit per cycle; out_valid high exactly WIDTH+1 cycles after acceptance.
REQ-023 out_valid, alu_res and flags SHALL hold stable while out_valid && !out_ready.
REQ-024 With MUL_EN = 0, opcode 1010 SHALL be treated as undefined per REQ-014.

Reset
REQ-025 While rst = 0: state IDLE, out_valid 0, alu_res 0, n/c/v 0, z 1, multiplier counter/accumulator 0, in_ready 0.
REQ-026 in_ready SHALL go high the first cycle after rst release.
REQ-027 Reset during MUL_BUSY or HOLD SHALL discard the operation; no result is emitted afterward.

Structure
REQ-028 Opcode constants, FSM state encoding, and flag-index constants SHALL reside in shared package alu_pkg.
REQ-029 The iterative multiplier SHALL be sub-module seq_multiplier (params WIDTH; start/busy/done handshake); all other logic in alu_seq.

Verification
REQ-030 WIDTH=32: ADD 0x7FFFFFFF + 0x1 -> alu_res 0x80000000, n=1 z=0 c=0 v=1, out_valid 1 cycle after accept.
REQ-031 WIDTH=32: SUB 5 - 5 -> 0, z=1 c=1 v=0; SBC 5 - 5 with c_in=0 -> 0xFFFFFFFF, n=1 c=0.
REQ-032 WIDTH=32: MUL 0x10000 * 0x10001 -> 0x00010000 (low bits), out_valid at cycle 33, in_ready 0 cycles 1..32.
REQ-033 Back-pressure: ADC 1+1, c_in=1 with out_ready=0 for 4 cycles -> alu_res 3 held stable, in_ready 0, then accepted next op same cycle out_ready rises.
REQ-034 Reset mid-MUL (cycle 10) -> out_valid stays 0, z=1, in_ready 1 cycle after release; next MOV 0xA5 -> alu_res 0xA5.
REQ-035 WIDTH=8: opcode 1111 -> alu_res 0x00, z=1; ADD 0xFF+0x01 -> 0x00, c=1 z=1 v=0.
